// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Newest producer wins: MEM is younger than WB. x0 is never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] rd_m, input logic wr_m,
                                        input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_M;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs1_e,
  input  logic [4:0] i_rs2_e,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_w,
  output logic [1:0] o_forward_a,
  output logic [1:0] o_forward_b
);

  assign o_forward_a = fwd_pick(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
  assign o_forward_b = fwd_pick(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward controller with memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [1:0]       resultSrc_E,
  input  logic             pcSrc_E,
  input  logic [4:0]       rd_M,
  input  logic             regWrite_M,
  input  logic [4:0]       rd_W,
  input  logic             regWrite_W,
  input  logic             memReq_M,
  input  logic             memReady_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             memTimeout,
  output logic [CNT_W-1:0] loadUseCnt,
  output logic [CNT_W-1:0] memWaitCnt,
  output logic             o_dbg_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  hz_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_mem_stall, w_load_use, w_lu_issue;
  logic [1:0]       w_fwd_a, w_fwd_b;

  assign w_mem_stall = memReq_M & ~memReady_M;
  assign w_load_use  = (resultSrc_E == RESULT_SRC_LOAD) && (rd_E != 5'd0) &&
                       ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign w_lu_issue  = w_load_use & ~w_mem_stall & ~pcSrc_E;

  forward_unit u_forward_unit (
    .i_rs1_e       (rs1_E),
    .i_rs2_e       (rs2_E),
    .i_rd_m        (rd_M),
    .i_reg_write_m (regWrite_M),
    .i_rd_w        (rd_W),
    .i_reg_write_w (regWrite_W),
    .o_forward_a   (w_fwd_a),
    .o_forward_b   (w_fwd_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // The FSM only measures wait duration; stalls come straight from the inputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      MEM_WAIT: begin
        if (w_mem_stall) begin
          if (r_wait_cnt != {CNT_W{1'b1}})
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end else begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
    if (w_mem_stall && (w_wait_cnt_nxt == TIMEOUT_VAL))
      w_timeout_nxt = 1'b1;
  end

  // Priority: memory stall > taken branch > load-use.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (reset) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_W = 1'b1;
    end else if (w_mem_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (pcSrc_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (w_load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  assign forwardA_E  = reset ? FWD_RF : w_fwd_a;
  assign forwardB_E  = reset ? FWD_RF : w_fwd_b;
  assign memTimeout  = r_timeout;
  assign o_dbg_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_lu_cnt, r_mw_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      if (w_lu_issue && (r_lu_cnt != {CNT_W{1'b1}}))
        r_lu_cnt <= r_lu_cnt + 1'b1;
      if (w_mem_stall && (r_mw_cnt != {CNT_W{1'b1}}))
        r_mw_cnt <= r_mw_cnt + 1'b1;
    end
  end

  assign loadUseCnt = r_lu_cnt;
  assign memWaitCnt = r_mw_cnt;
`else
  logic w_unused;
  assign w_unused   = w_lu_issue;
  assign loadUseCnt = '0;
  assign memWaitCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (built with MEM_TIMEOUT=4).
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk, reset;
  logic [4:0]       rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0]       resultSrc_E;
  logic             pcSrc_E, regWrite_M, regWrite_W, memReq_M, memReady_M;
  logic             stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic [1:0]       forwardA_E, forwardB_E;
  logic             memTimeout, o_dbg_state;
  logic [CNT_W-1:0] loadUseCnt, memWaitCnt;
  logic [6:0]       ctl;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .resultSrc_E(resultSrc_E), .pcSrc_E(pcSrc_E),
    .rd_M(rd_M), .regWrite_M(regWrite_M), .rd_W(rd_W), .regWrite_W(regWrite_W),
    .memReq_M(memReq_M), .memReady_M(memReady_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .memTimeout(memTimeout), .loadUseCnt(loadUseCnt), .memWaitCnt(memWaitCnt),
    .o_dbg_state(o_dbg_state)
  );

  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    resultSrc_E = 0; pcSrc_E = 0; regWrite_M = 0; regWrite_W = 0;
    memReq_M = 0; memReady_M = 0;
    #3;
    rs1_E = 5; rd_M = 5; regWrite_M = 1; rd_W = 5; regWrite_W = 1;
    #1;
    chk("rst_ctl", 32'(ctl), 32'h07);
    chk("rst_fwdA", 32'(forwardA_E), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    chk("rst_timeout", 32'(memTimeout), 32'd0);
    chk("rst_lucnt", 32'(loadUseCnt), 32'd0);
    chk("rst_mwcnt", 32'(memWaitCnt), 32'd0);

    tick(); reset = 1'b0; #2;
    chk("fwdA_M", 32'(forwardA_E), 32'd2);
    chk("fwd_ctl_idle", 32'(ctl), 32'h00);
    tick(); rd_M = 0; #2;
    chk("fwdA_W", 32'(forwardA_E), 32'd1);
    tick(); rd_W = 0; #2;
    chk("fwdA_RF", 32'(forwardA_E), 32'd0);
    tick(); rs2_E = 3; rd_W = 3; rd_M = 3; regWrite_M = 0; #2;
    chk("fwdB_W", 32'(forwardB_E), 32'd1);
    tick(); regWrite_M = 1; #2;
    chk("fwdB_M", 32'(forwardB_E), 32'd2);
    chk("fwdA_x0", 32'(forwardA_E), 32'd0);

    tick(); regWrite_M = 0; regWrite_W = 0;
    resultSrc_E = 2'b01; rd_E = 7; rs2_D = 7; #2;
    chk("lu_rs2", 32'(ctl), 32'h62);
    tick(); resultSrc_E = 2'b00; #2;
    chk("lu_release", 32'(ctl), 32'h00);
    tick(); resultSrc_E = 2'b01; rd_E = 9; rs1_D = 9; rs2_D = 0; #2;
    chk("lu_rs1", 32'(ctl), 32'h62);
    tick(); rd_E = 0; rs1_D = 0; #2;
    chk("lu_x0", 32'(ctl), 32'h00);
    tick(); rd_E = 7; rs2_D = 7; pcSrc_E = 1; #2;
    chk("branch_over_lu", 32'(ctl), 32'h06);
    tick(); pcSrc_E = 0; resultSrc_E = 2'b00; #2;
    chk("idle_after_br", 32'(ctl), 32'h00);

    tick(); memReq_M = 1; memReady_M = 0; #2;
    chk("mw1_ctl", 32'(ctl), 32'h79);
    chk("mw1_state", 32'(o_dbg_state), 32'd0);
    tick(); pcSrc_E = 1; #2;
    chk("mw2_ctl_br", 32'(ctl), 32'h79);
    chk("mw2_state", 32'(o_dbg_state), 32'd1);
    tick(); pcSrc_E = 0; #2;
    chk("mw3_ctl", 32'(ctl), 32'h79);
    tick(); memReady_M = 1; #2;
    chk("mw_ready_ctl", 32'(ctl), 32'h00);
    chk("mw_ready_state", 32'(o_dbg_state), 32'd1);
    tick(); memReq_M = 0; memReady_M = 0; #2;
    chk("mw_done_state", 32'(o_dbg_state), 32'd0);
    chk("mw_no_timeout", 32'(memTimeout), 32'd0);
    chk("perf_lu", 32'(loadUseCnt), PERF ? 32'd2 : 32'd0);
    chk("perf_mw", 32'(memWaitCnt), PERF ? 32'd3 : 32'd0);

    tick(); memReq_M = 1; memReady_M = 0;
    for (int i = 1; i <= 6; i++) begin
      #2;
      chk($sformatf("to_cycle%0d", i), 32'(memTimeout), (i >= 5) ? 32'd1 : 32'd0);
      tick();
    end
    memReady_M = 1; #2;
    chk("to_ready_flag", 32'(memTimeout), 32'd1);
    chk("to_ready_ctl", 32'(ctl), 32'h00);
    tick(); memReq_M = 0; memReady_M = 0; #2;
    chk("to_sticky", 32'(memTimeout), 32'd1);
    chk("to_state_run", 32'(o_dbg_state), 32'd0);
    chk("to_perf_mw", 32'(memWaitCnt), PERF ? 32'd9 : 32'd0);

    tick(); memReq_M = 1;
    tick();
    tick(); #2;
    chk("rw_state_wait", 32'(o_dbg_state), 32'd1);
    reset = 1'b1; #1;
    chk("rw_state_run", 32'(o_dbg_state), 32'd0);
    chk("rw_timeout_clr", 32'(memTimeout), 32'd0);
    chk("rw_ctl", 32'(ctl), 32'h07);
    chk("rw_perf_mw", 32'(memWaitCnt), 32'd0);
    tick(); reset = 1'b0; memReq_M = 0; #2;
    chk("post_rst_ctl", 32'(ctl), 32'h00);
    chk("post_rst_state", 32'(o_dbg_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
